// File: rtl/rr_output_allocator.sv
// rr_output_allocator: packet-level round-robin owner lock for one output.
// Optional stall watchdog enabled by defining ALLOC_TIMEOUT_EN.
module rr_output_allocator #(
    parameter int              LEN_W     = 12,
    parameter int              ID_W      = 3,
    parameter logic [ID_W-1:0] HEADER_ID = ID_W'(1),
    parameter int              TIMEOUT   = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         req,
    input  logic [5*ID_W-1:0]  flit_id,
    input  logic [5*LEN_W-1:0] length,
    input  logic               dcts,
    output logic [4:0]         grant,
    output logic [4:0]         sel,
    output logic               busy,
    output logic               timeout_err
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       owner_q, owner_d;
    logic [LEN_W-1:0] rem_q, rem_d;

    logic [4:0]       elig;
    logic             win_found;
    logic [2:0]       win_idx;
    logic [3:0]       sum;
    logic [2:0]       cand;
    logic [LEN_W-1:0] win_len;
    logic [4:0]       owner_oh;
    logic             go;
    logic             tmo_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_elig
            assign elig[gi] = req[gi] &&
                (flit_id[gi*ID_W +: ID_W] == HEADER_ID);
        end
    endgenerate

    // search eligible headers starting just after the last owner
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        sum       = 4'd0;
        cand      = 3'd0;
        for (int k = 1; k <= 5; k++) begin
            sum  = {1'b0, ptr_q} + 4'(k);
            cand = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_len  = length[int'(win_idx)*LEN_W +: LEN_W];
    assign owner_oh = 5'(1) << owner_q;
    assign go       = req[owner_q] && dcts;

`ifdef ALLOC_TIMEOUT_EN
    localparam int STALL_W = 16;
    logic [STALL_W-1:0] stall_q;

    // stall counter: cleared on grant or outside HOLD
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE || grant != 5'd0)
            stall_q <= '0;
        else
            stall_q <= stall_q + 1'b1;
    end

    assign tmo_hit = (state_q == HOLD) &&
        (stall_q == STALL_W'(TIMEOUT));
`else
    assign tmo_hit = 1'b0;
`endif

    // next-state, counter and output decode
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        rem_d       = rem_q;
        grant       = 5'd0;
        sel         = 5'd0;
        busy        = 1'b0;
        timeout_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = HOLD;
                    owner_d = win_idx;
                    rem_d   = (win_len == '0) ? LEN_W'(1) : win_len;
                end
            end
            HOLD: begin
                sel  = owner_oh;
                busy = 1'b1;
                if (tmo_hit) begin
                    timeout_err = 1'b1;
                    state_d     = IDLE;
                    ptr_d       = owner_q;
                end else if (go) begin
                    grant = owner_oh;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = IDLE;
                        ptr_d   = owner_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd4;
            owner_q <= 3'd0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_rr_output_allocator.sv
// tb_rr_output_allocator: directed checks of lock, rotation and stalls.
// Built with ALLOC_TIMEOUT_EN undefined.
module tb_rr_output_allocator;

    localparam int LEN_W = 12;
    localparam int ID_W  = 3;
    localparam logic [2:0] HDR  = 3'b001;
    localparam logic [2:0] BODY = 3'b010;

    logic               clk;
    logic               rst;
    logic [4:0]         req;
    logic [5*ID_W-1:0]  flit_id;
    logic [5*LEN_W-1:0] length;
    logic               dcts;
    logic [4:0]         grant;
    logic [4:0]         sel;
    logic               busy;
    logic               timeout_err;

    int errors;
    int checks;

    rr_output_allocator dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .flit_id     (flit_id),
        .length      (length),
        .dcts        (dcts),
        .grant       (grant),
        .sel         (sel),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p,
                            input logic [2:0] id,
                            input logic [11:0] l);
        flit_id[p*ID_W +: ID_W]   = id;
        length[p*LEN_W +: LEN_W]  = l;
    endtask

    task automatic cyc(input string tag,
                       input logic [4:0] eg,
                       input logic [4:0] es,
                       input logic eb);
        #1;
        check({tag, ".grant"}, 32'(grant), 32'(eg));
        check({tag, ".sel"}, 32'(sel), 32'(es));
        check({tag, ".busy"}, 32'(busy), 32'(eb));
        check({tag, ".tmo"}, 32'(timeout_err), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        req     = 5'd0;
        flit_id = '0;
        length  = '0;
        dcts    = 1'b1;
        do_reset();

        // reset / idle
        cyc("rst", 5'd0, 5'd0, 1'b0);

        // N packet, length 4
        set_port(1, HDR, 12'd4);
        req = 5'b00010;
        cyc("n.t", 5'd0, 5'd0, 1'b0);
        set_port(1, BODY, 12'd4);
        cyc("n.f1", 5'b00010, 5'b00010, 1'b1);
        cyc("n.f2", 5'b00010, 5'b00010, 1'b1);
        cyc("n.f3", 5'b00010, 5'b00010, 1'b1);
        cyc("n.f4", 5'b00010, 5'b00010, 1'b1);
        cyc("n.bub", 5'd0, 5'd0, 1'b0);
        req = 5'd0;

        // L, E, S simultaneous with ptr=4
        do_reset();
        set_port(0, HDR, 12'd1);
        set_port(2, HDR, 12'd1);
        set_port(4, HDR, 12'd1);
        req = 5'b10101;
        cyc("r1.t", 5'd0, 5'd0, 1'b0);
        cyc("r1.L", 5'b00001, 5'b00001, 1'b1);
        req[0] = 1'b0;
        cyc("r1.b1", 5'd0, 5'd0, 1'b0);
        cyc("r1.E", 5'b00100, 5'b00100, 1'b1);
        req[2] = 1'b0;
        cyc("r1.b2", 5'd0, 5'd0, 1'b0);
        cyc("r1.S", 5'b10000, 5'b10000, 1'b1);
        req = 5'd0;
        cyc("r1.b3", 5'd0, 5'd0, 1'b0);

        // L alone leaves ptr=0, then E, S, L
        req = 5'b00001;
        cyc("r2.t", 5'd0, 5'd0, 1'b0);
        cyc("r2.L0", 5'b00001, 5'b00001, 1'b1);
        req = 5'b10101;
        cyc("r2.b0", 5'd0, 5'd0, 1'b0);
        cyc("r2.E", 5'b00100, 5'b00100, 1'b1);
        req[2] = 1'b0;
        cyc("r2.b1", 5'd0, 5'd0, 1'b0);
        cyc("r2.S", 5'b10000, 5'b10000, 1'b1);
        req[4] = 1'b0;
        cyc("r2.b2", 5'd0, 5'd0, 1'b0);
        cyc("r2.L", 5'b00001, 5'b00001, 1'b1);
        req = 5'd0;
        cyc("r2.b3", 5'd0, 5'd0, 1'b0);

        // W locked, L header mid-packet
        do_reset();
        set_port(3, HDR, 12'd3);
        set_port(0, HDR, 12'd1);
        req = 5'b01000;
        cyc("w.t", 5'd0, 5'd0, 1'b0);
        cyc("w.f1", 5'b01000, 5'b01000, 1'b1);
        set_port(3, BODY, 12'd3);
        req = 5'b01001;
        cyc("w.f2", 5'b01000, 5'b01000, 1'b1);
        cyc("w.f3", 5'b01000, 5'b01000, 1'b1);
        req = 5'b00001;
        cyc("w.bub", 5'd0, 5'd0, 1'b0);
        cyc("w.L", 5'b00001, 5'b00001, 1'b1);
        req = 5'd0;
        cyc("w.end", 5'd0, 5'd0, 1'b0);

        // dcts 1,0,0,1,1 on E length 3
        do_reset();
        set_port(2, HDR, 12'd3);
        req = 5'b00100;
        cyc("d.t", 5'd0, 5'd0, 1'b0);
        set_port(2, BODY, 12'd3);
        dcts = 1'b1;
        cyc("d.1", 5'b00100, 5'b00100, 1'b1);
        dcts = 1'b0;
        cyc("d.2", 5'd0, 5'b00100, 1'b1);
        cyc("d.3", 5'd0, 5'b00100, 1'b1);
        dcts = 1'b1;
        cyc("d.4", 5'b00100, 5'b00100, 1'b1);
        cyc("d.5", 5'b00100, 5'b00100, 1'b1);
        cyc("d.rel", 5'd0, 5'd0, 1'b0);
        req = 5'd0;

        // length 0 on N, then length 1 on S
        do_reset();
        set_port(1, HDR, 12'd0);
        req = 5'b00010;
        cyc("z.t", 5'd0, 5'd0, 1'b0);
        cyc("z.g", 5'b00010, 5'b00010, 1'b1);
        set_port(1, BODY, 12'd0);
        cyc("z.b1", 5'd0, 5'd0, 1'b0);
        cyc("z.b2", 5'd0, 5'd0, 1'b0);
        set_port(4, HDR, 12'd1);
        req = 5'b10000;
        cyc("o.t", 5'd0, 5'd0, 1'b0);
        cyc("o.g", 5'b10000, 5'b10000, 1'b1);
        set_port(4, BODY, 12'd1);
        cyc("o.b1", 5'd0, 5'd0, 1'b0);
        cyc("o.b2", 5'd0, 5'd0, 1'b0);
        req = 5'd0;

        // reset while holding with remaining=5
        do_reset();
        set_port(0, HDR, 12'd5);
        req  = 5'b00001;
        dcts = 1'b0;
        cyc("m.t", 5'd0, 5'd0, 1'b0);
        set_port(0, BODY, 12'd5);
        cyc("m.hold", 5'd0, 5'b00001, 1'b1);
        rst = 1'b1;
        cyc("m.rst", 5'd0, 5'b00001, 1'b1);
        rst  = 1'b0;
        dcts = 1'b1;
        cyc("m.a1", 5'd0, 5'd0, 1'b0);
        cyc("m.a2", 5'd0, 5'd0, 1'b0);
        req = 5'd0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_output_allocator.md
# rr_output_allocator

- Packet-level round-robin allocator for one router output port.
- Arbitrates among the five input FIFOs (L, N, E, W, S) that request this output.
- Locks the output to the winner for the whole packet, using the header's length field, and drives the one-hot read grant and crossbar select.
- One instance per output port, between the flowcontrol ready outputs and the FIFO read-enable/xbar select logic.

## Interface
Parameters:
- LEN_W, 12, width of the packet length field (total flits incl. header)
- ID_W, 3, width of flit_id per port
- HEADER_ID, 3'b001, flit_id value marking a header flit
- TIMEOUT, 255, stall-cycle limit while locked (used only with the configuration macro)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, synchronous, active-high
- req  in  5  per-input request toward this output; bit0=L, 1=N, 2=E, 3=W, 4=S
- flit_id  in  5*ID_W  packed flit ids; port i at [i*ID_W +: ID_W]
- length  in  5*LEN_W  packed raw length fields; port i at [i*LEN_W +: LEN_W]
- dcts  in  1  downstream clear-to-send for this output
- grant  out  5  one-hot read grant: one flit moves this cycle
- sel  out  5  one-hot crossbar select of the current owner; 0 when idle
- busy  out  1  output locked to a packet
- timeout_err  out  1  one-cycle pulse on forced release (tied 0 when the macro is absent)

## Operation
- States: IDLE, HOLD.
- IDLE:
  - Port i is eligible when req[i]=1 and flit_id[i]==HEADER_ID.
  - Non-header requests are ignored.
  - Search order starts at (ptr+1) mod 5 and wraps.
  - The first eligible port becomes owner; the next state is HOLD.
  - remaining is loaded with length[owner]; a length of 0 is loaded as 1.
- HOLD:
  - sel = onehot(owner); busy = 1.
  - grant = onehot(owner) when req[owner] && dcts, else 0.
  - On each grant cycle, remaining decrements by 1.
  - A grant with remaining==1 releases the lock: next state IDLE, ptr <= owner.
- Without grant (req low or dcts low), HOLD persists and the counter holds.
- Other ports' requests never preempt the owner, including new headers.
- A single-flit packet (length 1 or 0) releases after its header grant.
- remaining is LEN_W bits unsigned and never underflows; release happens at 1.
- Reset:
  - Values: state=IDLE, ptr=4 (so L has first priority), owner=0, remaining=0.
  - Outputs: grant=0, sel=0, busy=0, timeout_err=0.
- Reset mid-packet drops the lock immediately; the rest of the packet is not tracked.

## Timing
- grant and sel are combinational from registered state plus req/dcts; no path runs from req to grant in the same cycle in IDLE.
- Arbitration latency:
  - Header requested at cycle t in IDLE: owner is registered at t+1.
  - The first grant is at t+1 if req and dcts hold.
- Throughput while locked: one flit per cycle when req and dcts are high.
- Mandatory single IDLE bubble after release: the earliest next-packet grant comes 2 cycles after the tail grant.
- Simultaneous headers: exactly one winner per ptr order; the losers keep requesting and win in later rounds.
- dcts dropping mid-packet stalls grant the same cycle; there is no lost or duplicated count.

## Configuration
- ALLOC_TIMEOUT_EN defined:
  - An 8..16-bit stall counter runs in HOLD; it clears on each grant and increments otherwise.
  - When it reaches TIMEOUT: force IDLE, ptr <= owner, pulse timeout_err for 1 cycle, no grant that cycle.
  - The counter resets to 0 on rst and on entering HOLD.
- ALLOC_TIMEOUT_EN undefined:
  - No stall counter; HOLD persists indefinitely.
  - timeout_err is constant 0.

## Test plan
- Reset, then idle: all outputs 0. Then N header with length=4 and dcts=1 held: sel=5'b00010 from t+1, four consecutive grants 5'b00010, busy falls after the 4th, one IDLE cycle follows.
- L, E, S headers asserted simultaneously after reset (ptr=4):
  - Order of service is L, E, S.
  - Repeated with ptr=0 after a completed L packet: E, S, L.
- W locked with length=3; L header arrives mid-packet: no L grant until W's 3rd flit granted plus one bubble.
- dcts toggled 1,0,0,1,1 during a length-3 packet: grants appear only on dcts=1 cycles, exactly 3 total, release after the third.
- Length 0 and length 1 headers: each receives exactly one grant; the body flit_id on the same port in IDLE is never granted.
- rst asserted while HOLD with remaining=5: next cycle all outputs 0. With ALLOC_TIMEOUT_EN, TIMEOUT=255: req held 0 for 255 cycles -> timeout_err pulse and release.
